// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of a single-port 1K x 16 memory
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [9:0]  iAdrs,
  output logic        iGnt,
  output logic        iValid,
  output logic [15:0] iDatOut,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [9:0]  dAdrs,
  input  logic [15:0] dDatIn,
  output logic        dGnt,
  output logic        dValid,
  output logic [15:0] dDatOut,
  output logic        memWea,
  output logic [9:0]  memAdrs,
  output logic [15:0] memDatIn,
  input  logic [15:0] memDatOut,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic valid;
    logic owner_d;
    logic is_store;
  } flight_t;

  state_t      state;
  logic [3:0]  starve_cnt;
  flight_t     pipe [RD_LAT];
  flight_t     tail;
  flight_t     issue;
  logic [9:0]  last_adrs;
  logic [15:0] last_dat;
  logic        d_win;
  logic        grant;
  logic        pipe_busy;

  // D has priority unless I has been passed over STARVE_MAX times in a row.
  always_comb begin
    d_win = dReq && !(iReq && (starve_cnt == 4'(STARVE_MAX)));
    dGnt  = !reset && d_win;
    iGnt  = !reset && iReq && !d_win;
    grant = iGnt || dGnt;
  end

  // The memory bus only moves on a grant; otherwise the last address/data stay put.
  always_comb begin
    memWea   = dGnt && dWe;
    memAdrs  = last_adrs;
    memDatIn = last_dat;
    if (dGnt) begin
      memAdrs  = dAdrs;
      memDatIn = dDatIn;
    end else if (iGnt) begin
      memAdrs  = iAdrs;
    end
  end

  always_comb begin
    issue.valid    = grant;
    issue.owner_d  = dGnt;
    issue.is_store = memWea;
    tail           = pipe[RD_LAT-1];
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      pipe_busy = pipe_busy | pipe[k].valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_adrs <= '0;
      last_dat  <= '0;
    end else if (grant) begin
      last_adrs <= memAdrs;
      last_dat  <= memDatIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (dGnt && iReq) begin
      if (starve_cnt != 4'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Grant-ordered shift register; its tail lines up with memDatOut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pipe[k] <= pipe[k-1];
      end
      pipe[0] <= issue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iValid  <= 1'b0;
      dValid  <= 1'b0;
      iDatOut <= '0;
      dDatOut <= '0;
    end else begin
      iValid <= tail.valid && !tail.owner_d;
      dValid <= tail.valid && tail.owner_d;
      if (tail.valid && !tail.owner_d) begin
        iDatOut <= memDatOut;
      end
      if (tail.valid && tail.owner_d && !tail.is_store) begin
        dDatOut <= memDatOut;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!grant) begin
            if (pipe_busy) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (grant) begin
            state <= RUN;
          end else if (!pipe_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at RD_LAT 1 and 3
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  typedef struct packed {
    logic [15:0] data;
    int          due;
    logic        store;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iReq = 1'b0;
  logic [9:0]  iAdrs = '0;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [9:0]  dAdrs = '0;
  logic [15:0] dDatIn = '0;

  logic        iGnt_1, iValid_1, dGnt_1, dValid_1, memWea_1, busy_1;
  logic [15:0] iDatOut_1, dDatOut_1, memDatIn_1, memDatOut_1;
  logic [9:0]  memAdrs_1;
  logic        iGnt_3, iValid_3, dGnt_3, dValid_3, memWea_3, busy_3;
  logic [15:0] iDatOut_3, dDatOut_3, memDatIn_3, memDatOut_3;
  logic [9:0]  memAdrs_3;

  logic [63:0] outs_1, outs_3;
  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];
  logic [15:0] rd_a;
  logic [15:0] rd_b [3];
  logic [15:0] ref_mem [1024];

  resp_t q_i1[$], q_d1[$], q_i3[$], q_d3[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starve = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(SMAX)) dut_1 (
    .clk(clk), .reset(reset), .iReq(iReq), .iAdrs(iAdrs), .iGnt(iGnt_1), .iValid(iValid_1),
    .iDatOut(iDatOut_1), .dReq(dReq), .dWe(dWe), .dAdrs(dAdrs), .dDatIn(dDatIn), .dGnt(dGnt_1),
    .dValid(dValid_1), .dDatOut(dDatOut_1), .memWea(memWea_1), .memAdrs(memAdrs_1),
    .memDatIn(memDatIn_1), .memDatOut(memDatOut_1), .busy(busy_1)
  );

  mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(SMAX)) dut_3 (
    .clk(clk), .reset(reset), .iReq(iReq), .iAdrs(iAdrs), .iGnt(iGnt_3), .iValid(iValid_3),
    .iDatOut(iDatOut_3), .dReq(dReq), .dWe(dWe), .dAdrs(dAdrs), .dDatIn(dDatIn), .dGnt(dGnt_3),
    .dValid(dValid_3), .dDatOut(dDatOut_3), .memWea(memWea_3), .memAdrs(memAdrs_3),
    .memDatIn(memDatIn_3), .memDatOut(memDatOut_3), .busy(busy_3)
  );

  assign outs_1 = {iGnt_1, dGnt_1, iValid_1, dValid_1, memWea_1, busy_1,
                   iDatOut_1, dDatOut_1, memAdrs_1, memDatIn_1};
  assign outs_3 = {iGnt_3, dGnt_3, iValid_3, dValid_3, memWea_3, busy_3,
                   iDatOut_3, dDatOut_3, memAdrs_3, memDatIn_3};

  // Memory models: registered read, then RD_LAT-1 extra output stages.
  always @(posedge clk) begin
    if (memWea_1) mem_a[memAdrs_1] <= memDatIn_1;
    rd_a <= memWea_1 ? memDatIn_1 : mem_a[memAdrs_1];
  end
  assign memDatOut_1 = rd_a;

  always @(posedge clk) begin
    if (memWea_3) mem_b[memAdrs_3] <= memDatIn_3;
    rd_b[0] <= memWea_3 ? memDatIn_3 : mem_b[memAdrs_3];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign memDatOut_3 = rd_b[2];

  always @(negedge clk) begin
    resp_t e;
    if (iValid_1) begin
      total++;
      if (q_i1.size() == 0) begin
        bad++; $display("FAIL resp_i1: iValid at cycle %0d, required no response", cyc);
      end else begin
        e = q_i1.pop_front();
        if (iDatOut_1 !== e.data || cyc != e.due) begin
          bad++; $display("FAIL resp_i1: data=%h cycle=%0d, required data=%h cycle=%0d", iDatOut_1, cyc, e.data, e.due);
        end
      end
    end else if (q_i1.size() != 0 && q_i1[0].due <= cyc) begin
      total++; bad++; e = q_i1.pop_front();
      $display("FAIL resp_i1: no iValid at cycle %0d, required data=%h", cyc, e.data);
    end
    if (dValid_1) begin
      total++;
      if (q_d1.size() == 0) begin
        bad++; $display("FAIL resp_d1: dValid at cycle %0d, required no response", cyc);
      end else begin
        e = q_d1.pop_front();
        if ((!e.store && dDatOut_1 !== e.data) || cyc != e.due) begin
          bad++; $display("FAIL resp_d1: data=%h cycle=%0d, required data=%h cycle=%0d", dDatOut_1, cyc, e.data, e.due);
        end
      end
    end else if (q_d1.size() != 0 && q_d1[0].due <= cyc) begin
      total++; bad++; e = q_d1.pop_front();
      $display("FAIL resp_d1: no dValid at cycle %0d, required data=%h", cyc, e.data);
    end
    if (iValid_3) begin
      total++;
      if (q_i3.size() == 0) begin
        bad++; $display("FAIL resp_i3: iValid at cycle %0d, required no response", cyc);
      end else begin
        e = q_i3.pop_front();
        if (iDatOut_3 !== e.data || cyc != e.due) begin
          bad++; $display("FAIL resp_i3: data=%h cycle=%0d, required data=%h cycle=%0d", iDatOut_3, cyc, e.data, e.due);
        end
      end
    end else if (q_i3.size() != 0 && q_i3[0].due <= cyc) begin
      total++; bad++; e = q_i3.pop_front();
      $display("FAIL resp_i3: no iValid at cycle %0d, required data=%h", cyc, e.data);
    end
    if (dValid_3) begin
      total++;
      if (q_d3.size() == 0) begin
        bad++; $display("FAIL resp_d3: dValid at cycle %0d, required no response", cyc);
      end else begin
        e = q_d3.pop_front();
        if ((!e.store && dDatOut_3 !== e.data) || cyc != e.due) begin
          bad++; $display("FAIL resp_d3: data=%h cycle=%0d, required data=%h cycle=%0d", dDatOut_3, cyc, e.data, e.due);
        end
      end
    end else if (q_d3.size() != 0 && q_d3[0].due <= cyc) begin
      total++; bad++; e = q_d3.pop_front();
      $display("FAIL resp_d3: no dValid at cycle %0d, required data=%h", cyc, e.data);
    end
  end

  // One cycle of stimulus; the model decides the winner and queues expected responses.
  task automatic step(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                      input logic [9:0] da, input logic [15:0] dd,
                      output logic [2:0] g, output int c, output logic b3);
    logic  ed, ei;
    resp_t r;
    iReq = ir; iAdrs = ia; dReq = dr; dWe = dw; dAdrs = da; dDatIn = dd;
    @(negedge clk);
    g  = {iGnt_1, dGnt_1, memWea_1};
    c  = cyc;
    b3 = busy_3;
    ed = dr && !(ir && starve == SMAX);
    ei = ir && !ed;
    if (ed && ir) starve = (starve == SMAX) ? SMAX : starve + 1;
    else starve = 0;
    if (ei) begin
      r.data = ref_mem[ia]; r.store = 1'b0;
      r.due = c + 2; q_i1.push_back(r);
      r.due = c + 4; q_i3.push_back(r);
    end
    if (ed) begin
      if (dw) ref_mem[da] = dd;
      r.data = ref_mem[da]; r.store = dw;
      r.due = c + 2; q_d1.push_back(r);
      r.due = c + 4; q_d3.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [2:0] g; int c; logic b;
    for (int k = 0; k < n; k++) step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, g, c, b);
  endtask

  task automatic flush();
    q_i1.delete(); q_d1.delete(); q_i3.delete(); q_d3.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush(); starve = 0;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; iAdrs = '0; dAdrs = '0; dDatIn = '0;
    @(negedge clk);
    total++;
    if ({outs_1, outs_3} !== 128'd0) begin
      bad++; $display("FAIL reset_outs: got %h %h, required all zero", outs_1, outs_3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      total++;
      if ({outs_1, outs_3} !== 128'd0) begin
        bad++; $display("FAIL idle_outs: cycle %0d got %h %h, required all zero", n, outs_1, outs_3);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [2:0] g; int c; logic b;
    step(1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 16'hBEEF, g, c, b);
    total++;
    if (g !== 3'b011) begin bad++; $display("FAIL store_grant: {iGnt,dGnt,memWea}=%b, required 011", g); end
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 16'h0000, g, c, b);
    total++;
    if (g !== 3'b010) begin bad++; $display("FAIL load_grant: {iGnt,dGnt,memWea}=%b, required 010", g); end
    idle(6);
    total++;
    if (q_d1.size() + q_d3.size() != 0) begin
      bad++; $display("FAIL store_load_drain: %0d responses pending, required 0", q_d1.size() + q_d3.size());
    end
  endtask

  task automatic test_fetch_burst();
    logic [2:0] g; int c; logic b;
    for (int a = 0; a < 5; a++) begin
      step(1'b0, 10'd0, 1'b1, 1'b1, 10'(a), 16'(a), g, c, b);
      total++;
      if (g !== 3'b011) begin bad++; $display("FAIL preload_grant: adrs %0d got %b, required 011", a, g); end
    end
    for (int a = 0; a < 5; a++) begin
      step(1'b1, 10'(a), 1'b0, 1'b0, 10'd0, 16'd0, g, c, b);
      total++;
      if (g !== 3'b100) begin bad++; $display("FAIL fetch_grant: adrs %0d got %b, required 100", a, g); end
    end
    idle(6);
    total++;
    if (q_i1.size() + q_i3.size() + q_d1.size() + q_d3.size() != 0) begin
      bad++; $display("FAIL fetch_drain: responses still pending, required none");
    end
  endtask

  task automatic test_starvation();
    logic [2:0] g; int c; logic b;
    logic [2:0] exp_g;
    int ia = 0;
    for (int n = 0; n < 12; n++) begin
      exp_g = (n % 4 == 3) ? 3'b100 : 3'b010;
      step(1'b1, 10'(ia), 1'b1, 1'b0, 10'(n % 5), 16'd0, g, c, b);
      total++;
      if (g !== exp_g) begin bad++; $display("FAIL starve_grant: slot %0d got %b, required %b", n, g, exp_g); end
      if (exp_g == 3'b100) ia = (ia + 1) % 5;
    end
    idle(6);
    total++;
    if (q_i1.size() + q_i3.size() + q_d1.size() + q_d3.size() != 0) begin
      bad++; $display("FAIL starve_drain: responses still pending, required none");
    end
  endtask

  task automatic test_reset_midflight();
    logic [2:0] g; int c; logic b;
    step(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 16'd0, g, c, b);
    total++;
    if (g !== 3'b010) begin bad++; $display("FAIL mid_d_grant: got %b, required 010", g); end
    step(1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 16'd0, g, c, b);
    total++;
    if (g !== 3'b100) begin bad++; $display("FAIL mid_i_grant: got %b, required 100", g); end
    iReq = 1'b0; dReq = 1'b0; iAdrs = '0; dAdrs = '0;
    reset = 1'b1; flush(); starve = 0;
    @(negedge clk);
    total++;
    if ({outs_1, outs_3} !== 128'd0) begin
      bad++; $display("FAIL mid_reset_outs: got %h %h, required all zero", outs_1, outs_3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    total++;
    if ({busy_1, busy_3} !== 2'b00) begin bad++; $display("FAIL mid_busy: got %b, required 00", {busy_1, busy_3}); end
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd3, 16'd0, g, c, b);
    total++;
    if (g !== 3'b010) begin bad++; $display("FAIL post_reset_grant: got %b, required 010", g); end
    idle(6);
    total++;
    if (q_d1.size() + q_d3.size() != 0) begin
      bad++; $display("FAIL post_reset_drain: responses pending, required none");
    end
  endtask

  task automatic test_rdlat3_drain();
    logic [2:0] g; int c; logic b;
    int last = 0;
    for (int a = 0; a < 5; a++) begin
      step(1'b1, 10'(a), 1'b0, 1'b0, 10'd0, 16'd0, g, c, b);
      total++;
      if (g !== 3'b100) begin bad++; $display("FAIL lat3_grant: adrs %0d got %b, required 100", a, g); end
      last = c;
    end
    for (int n = 0; n < 7; n++) begin
      step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, g, c, b);
      total++;
      if (b !== (c <= last + 4)) begin
        bad++; $display("FAIL lat3_busy: cycle %0d busy=%b, required %b", c - last, b, (c <= last + 4));
      end
    end
    total++;
    if (q_i3.size() + q_i1.size() != 0) begin
      bad++; $display("FAIL lat3_drain: responses pending, required none");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_fetch_burst();
    test_starvation();
    test_reset_midflight();
    test_rdlat3_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
